// File: rtl/instr_encoder_loader_if.sv
// Command / instruction-memory bus for the instruction encoder-loader.
//   master : the side that issues symbolic commands and owns the instruction
//            memory (e.g. a bench or the boot controller)
//   slave  : the encoder-loader itself
// Signals:
//   cmd_valid/cmd_ready/cmd_last   command handshake, cmd_last marks the end of the program
//   cmd_mnem                       mnemonic index (0..34 legal)
//   cmd_rs/rt/rd/shamt             register and shift fields
//   cmd_imm                        imm16 in [15:0] or a 26-bit jump target
//   im_we/im_addr/im_wdata         instruction-memory write port
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 10
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_last;
    logic [5:0]        cmd_mnem;
    logic [4:0]        cmd_rs;
    logic [4:0]        cmd_rt;
    logic [4:0]        cmd_rd;
    logic [4:0]        cmd_shamt;
    logic [25:0]       cmd_imm;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;

    modport master (
        output cmd_valid, cmd_last, cmd_mnem, cmd_rs, cmd_rt, cmd_rd, cmd_shamt, cmd_imm,
        input  cmd_ready, im_we, im_addr, im_wdata
    );

    modport slave (
        input  cmd_valid, cmd_last, cmd_mnem, cmd_rs, cmd_rt, cmd_rd, cmd_shamt, cmd_imm,
        output cmd_ready, im_we, im_addr, im_wdata
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Instruction encoder-loader: turns symbolic instruction commands into 32-bit
// MIPS words (R/I/J subset) and writes them to consecutive instruction-memory
// addresses starting at base_addr.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   start        begin a load at base_addr (honoured in IDLE and FULL)
//   base_addr    first word address of the load
//   bus          command handshake in, instruction-memory write port out
//   busy         loader is not idle
//   done         one-cycle pulse in the cycle of the final write
//   full         top of memory reached without cmd_last
//   err_illegal  one-cycle pulse when an illegal mnemonic is dropped
//   illegal_cnt  saturating count of dropped commands
module instr_encoder_loader #(
    parameter int ADDR_W = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      base_addr,
    instr_encoder_loader_if.slave  bus,
    output logic                   busy,
    output logic                   done,
    output logic                   full,
    output logic                   err_illegal,
    output logic [7:0]             illegal_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_FULL
    } state_t;

    localparam int NUM_MNEM = 35;

    // Packed code table, entry 0 in the least significant bits.
    // Entries 0..17 are R-type funct codes, 18..34 are primary opcodes.
    localparam logic [NUM_MNEM*6-1:0] CODE_TABLE = {
        6'h03, 6'h02, 6'h2B, 6'h29, 6'h28, 6'h25, 6'h24, 6'h23, 6'h21,  // 34..26
        6'h20, 6'h05, 6'h04, 6'h0F, 6'h0D, 6'h0C, 6'h0A, 6'h08,         // 25..18
        6'h09, 6'h08, 6'h07, 6'h06, 6'h04, 6'h03, 6'h02, 6'h00, 6'h2B,  // 17..9
        6'h2A, 6'h27, 6'h26, 6'h25, 6'h24, 6'h23, 6'h22, 6'h21, 6'h20   // 8..0
    };

    logic [5:0] code_tbl [NUM_MNEM];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MNEM; gi++) begin : g_code
            assign code_tbl[gi] = CODE_TABLE[gi*6 +: 6];
        end
    endgenerate

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic                im_we_reg, im_we_next;
    logic [ADDR_W-1:0]   im_addr_reg, im_addr_next;
    logic [31:0]         im_wdata_reg, im_wdata_next;
    logic                err_illegal_reg, err_illegal_next;
    logic [7:0]          illegal_cnt_reg, illegal_cnt_next;

    // ---------------- encoder ----------------
    logic        legal;
    logic        is_r, is_shift, is_jr, is_jalr, is_j, is_lui;
    logic [5:0]  code;
    logic [31:0] enc_word;

    always_comb begin
        legal    = (bus.cmd_mnem < 6'd35);
        code     = legal ? code_tbl[bus.cmd_mnem] : 6'd0;
        is_r     = (bus.cmd_mnem <= 6'd17);
        is_shift = (bus.cmd_mnem >= 6'd10) && (bus.cmd_mnem <= 6'd12);
        is_jr    = (bus.cmd_mnem == 6'd16);
        is_jalr  = (bus.cmd_mnem == 6'd17);
        is_j     = (bus.cmd_mnem == 6'd33) || (bus.cmd_mnem == 6'd34);
        is_lui   = (bus.cmd_mnem == 6'd22);
        enc_word = 32'd0;
        if (is_j) begin
            enc_word = {code, bus.cmd_imm};
        end else if (!is_r) begin
            enc_word = {code, (is_lui ? 5'd0 : bus.cmd_rs), bus.cmd_rt, bus.cmd_imm[15:0]};
        end else if (is_jr) begin
            enc_word = {6'd0, bus.cmd_rs, 15'd0, code};
        end else if (is_jalr) begin
            enc_word = {6'd0, bus.cmd_rs, 5'd0, bus.cmd_rd, 5'd0, code};
        end else if (is_shift) begin
            // constant shifts take the amount from shamt and have no rs
            enc_word = {6'd0, 5'd0, bus.cmd_rt, bus.cmd_rd, bus.cmd_shamt, code};
        end else begin
            enc_word = {6'd0, bus.cmd_rs, bus.cmd_rt, bus.cmd_rd, 5'd0, code};
        end
    end

    // ---------------- control ----------------
    logic accept;
    logic at_top;

    assign accept = bus.cmd_valid && (state_reg == ST_RUN);
    assign at_top = (wr_ptr_reg == {ADDR_W{1'b1}});

    always_comb begin
        state_next       = state_reg;
        wr_ptr_next      = wr_ptr_reg;
        im_we_next       = 1'b0;
        im_addr_next     = im_addr_reg;
        im_wdata_next    = im_wdata_reg;
        err_illegal_next = 1'b0;
        illegal_cnt_next = illegal_cnt_reg;
        case (state_reg)
            ST_IDLE, ST_FULL: begin
                if (start) begin
                    state_next  = ST_RUN;
                    wr_ptr_next = base_addr;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (legal) begin
                        im_we_next    = 1'b1;
                        im_addr_next  = wr_ptr_reg;
                        im_wdata_next = enc_word;
                        // pointer never wraps; the top slot sends us to FULL instead
                        if (!at_top) begin
                            wr_ptr_next = wr_ptr_reg + 1'b1;
                        end
                        if (bus.cmd_last) begin
                            state_next = ST_DRAIN;
                        end else if (at_top) begin
                            state_next = ST_FULL;
                        end
                    end else begin
                        err_illegal_next = 1'b1;
                        if (illegal_cnt_reg != 8'hFF) begin
                            illegal_cnt_next = illegal_cnt_reg + 8'd1;
                        end
                        if (bus.cmd_last) begin
                            state_next = ST_DRAIN;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            wr_ptr_reg      <= '0;
            im_we_reg       <= 1'b0;
            im_addr_reg     <= '0;
            im_wdata_reg    <= 32'd0;
            err_illegal_reg <= 1'b0;
            illegal_cnt_reg <= 8'd0;
        end else begin
            state_reg       <= state_next;
            wr_ptr_reg      <= wr_ptr_next;
            im_we_reg       <= im_we_next;
            im_addr_reg     <= im_addr_next;
            im_wdata_reg    <= im_wdata_next;
            err_illegal_reg <= err_illegal_next;
            illegal_cnt_reg <= illegal_cnt_next;
        end
    end

    // A write still pending when reset arrives must not reach the memory,
    // so the strobe is masked by rst in the same cycle.
    assign bus.im_we     = im_we_reg && !rst;
    assign bus.im_addr   = im_addr_reg;
    assign bus.im_wdata  = im_wdata_reg;
    assign bus.cmd_ready = (state_reg == ST_RUN);
    assign busy          = (state_reg != ST_IDLE);
    assign done          = (state_reg == ST_DRAIN);
    assign full          = (state_reg == ST_FULL);
    assign err_illegal   = err_illegal_reg;
    assign illegal_cnt   = illegal_cnt_reg;

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;
    localparam int AW  = 10;
    localparam int AW2 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start, start2;
    logic [AW-1:0] base_addr;
    logic [AW2-1:0] base_addr2;
    logic          busy, done, full, err_illegal;
    logic [7:0]    illegal_cnt;
    logic          busy2, done2, full2, err_illegal2;
    logic [7:0]    illegal_cnt2;

    instr_encoder_loader_if #(.ADDR_W(AW))  bus ();
    instr_encoder_loader_if #(.ADDR_W(AW2)) bus2 ();

    instr_encoder_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .bus(bus.slave),
        .busy(busy), .done(done), .full(full), .err_illegal(err_illegal), .illegal_cnt(illegal_cnt)
    );

    instr_encoder_loader #(.ADDR_W(AW2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .base_addr(base_addr2), .bus(bus2.slave),
        .busy(busy2), .done(done2), .full(full2), .err_illegal(err_illegal2), .illegal_cnt(illegal_cnt2)
    );

    int errors = 0;
    int checks = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [5:0] m, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [4:0] sh, input logic [25:0] imm,
                           input logic last);
        bus.cmd_valid = 1'b1; bus.cmd_mnem = m; bus.cmd_rs = rs; bus.cmd_rt = rt;
        bus.cmd_rd = rd; bus.cmd_shamt = sh; bus.cmd_imm = imm; bus.cmd_last = last;
    endtask

    task automatic set_cmd2(input logic [5:0] m, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [25:0] imm, input logic last);
        bus2.cmd_valid = 1'b1; bus2.cmd_mnem = m; bus2.cmd_rs = rs; bus2.cmd_rt = rt;
        bus2.cmd_rd = rd; bus2.cmd_shamt = 5'd0; bus2.cmd_imm = imm; bus2.cmd_last = last;
    endtask

    task automatic clear_cmd();
        bus.cmd_valid = 1'b0; bus.cmd_last = 1'b0;
        bus2.cmd_valid = 1'b0; bus2.cmd_last = 1'b0;
    endtask

    task automatic do_start(input logic [AW-1:0] b);
        start = 1'b1; base_addr = b;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start2 = 1'b0; base_addr = '0; base_addr2 = '0;
        clear_cmd();
        set_cmd(6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0);
        bus.cmd_valid = 1'b0;
        set_cmd2(6'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0);
        bus2.cmd_valid = 1'b0;
        step(); step();
        rst = 1'b0;
        checks++;
        if ({bus.im_we, bus.cmd_ready, busy, done, full, err_illegal} !== 6'b0 ||
            illegal_cnt !== 8'd0 || bus.im_addr !== '0 || bus.im_wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: we/ready/busy/done/full/err=%b cnt=%0d addr=%0d data=%h, required all zero",
                     {bus.im_we, bus.cmd_ready, busy, done, full, err_illegal}, illegal_cnt, bus.im_addr, bus.im_wdata);
        end
        $display("reset: outputs checked");
    endtask

    // T1: single add carrying last
    task automatic test_single();
        do_start(0);
        checks++;
        if (bus.cmd_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_run: ready=%b busy=%b, required 1 1", bus.cmd_ready, busy);
        end
        set_cmd(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0, 1'b1);
        step();
        clear_cmd();
        $display("t1 write we=%b addr=%0d data=%h done=%b", bus.im_we, bus.im_addr, bus.im_wdata, done);
        checks++;
        if (bus.im_we !== 1'b1 || bus.im_addr !== 10'd0 || bus.im_wdata !== 32'h00221820 || done !== 1'b1) begin
            errors++;
            $display("FAIL t1_add: we=%b addr=%0d data=%h done=%b, required 1 0 00221820 1",
                     bus.im_we, bus.im_addr, bus.im_wdata, done);
        end
        step();
        checks++;
        if (bus.im_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL t1_idle: we=%b busy=%b done=%b, required 0 0 0", bus.im_we, busy, done);
        end
    endtask

    // T2: back-to-back I-type with last on the third
    task automatic test_back_to_back();
        logic [5:0]  m   [3];
        logic [4:0]  rs  [3];
        logic [4:0]  rt  [3];
        logic [25:0] imm [3];
        logic [31:0] exp [3];
        m[0] = 6'd18; rs[0] = 5'd0;  rt[0] = 5'd8; imm[0] = 26'h0005; exp[0] = 32'h20080005;
        m[1] = 6'd22; rs[1] = 5'd7;  rt[1] = 5'd1; imm[1] = 26'h1234; exp[1] = 32'h3C011234;
        m[2] = 6'd32; rs[2] = 5'd29; rt[2] = 5'd2; imm[2] = 26'h0004; exp[2] = 32'hAFA20004;
        do_start(0);
        for (int i = 0; i < 3; i++) begin
            set_cmd(m[i], rs[i], rt[i], 5'd0, 5'd0, imm[i], (i == 2));
            step();
            $display("t2 write we=%b addr=%0d data=%h done=%b", bus.im_we, bus.im_addr, bus.im_wdata, done);
            checks++;
            if (bus.im_we !== 1'b1 || bus.im_addr !== AW'(i) || bus.im_wdata !== exp[i] || done !== (i == 2)) begin
                errors++;
                $display("FAIL t2_word%0d: we=%b addr=%0d data=%h done=%b, required 1 %0d %h %b",
                         i, bus.im_we, bus.im_addr, bus.im_wdata, done, i, exp[i], (i == 2));
            end
        end
        clear_cmd();
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL t2_idle: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    // T3: shifts, jr/jalr, branch, jumps with unused fields forced to zero
    task automatic test_formats();
        logic [5:0]  m   [7];
        logic [4:0]  rs  [7];
        logic [4:0]  rt  [7];
        logic [4:0]  rd  [7];
        logic [4:0]  sh  [7];
        logic [25:0] imm [7];
        logic [31:0] exp [7];
        m[0]=6'd10; rs[0]=5'd9;  rt[0]=5'd1; rd[0]=5'd2;  sh[0]=5'd4;  imm[0]=26'h0;       exp[0]=32'h00011100;
        m[1]=6'd16; rs[1]=5'd31; rt[1]=5'd5; rd[1]=5'd6;  sh[1]=5'd3;  imm[1]=26'h0;       exp[1]=32'h03E00008;
        m[2]=6'd17; rs[2]=5'd4;  rt[2]=5'd7; rd[2]=5'd31; sh[2]=5'd2;  imm[2]=26'h0;       exp[2]=32'h0080F809;
        m[3]=6'd23; rs[3]=5'd1;  rt[3]=5'd2; rd[3]=5'd9;  sh[3]=5'd9;  imm[3]=26'h3FFFFFF; exp[3]=32'h1022FFFF;
        m[4]=6'd12; rs[4]=5'd8;  rt[4]=5'd3; rd[4]=5'd4;  sh[4]=5'd31; imm[4]=26'h0;       exp[4]=32'h000327C3;
        m[5]=6'd34; rs[5]=5'd1;  rt[5]=5'd1; rd[5]=5'd1;  sh[5]=5'd1;  imm[5]=26'h3FFFFFF; exp[5]=32'h0FFFFFFF;
        m[6]=6'd33; rs[6]=5'd3;  rt[6]=5'd3; rd[6]=5'd3;  sh[6]=5'd3;  imm[6]=26'h0100000; exp[6]=32'h08100000;
        do_start(10'd5);
        for (int i = 0; i < 7; i++) begin
            set_cmd(m[i], rs[i], rt[i], rd[i], sh[i], imm[i], (i == 6));
            step();
            $display("t3 write mnem=%0d addr=%0d data=%h", m[i], bus.im_addr, bus.im_wdata);
            checks++;
            if (bus.im_we !== 1'b1 || bus.im_addr !== AW'(5 + i) || bus.im_wdata !== exp[i]) begin
                errors++;
                $display("FAIL t3_mnem%0d: we=%b addr=%0d data=%h, required 1 %0d %h",
                         m[i], bus.im_we, bus.im_addr, bus.im_wdata, 5 + i, exp[i]);
            end
        end
        clear_cmd();
        step();
    endtask

    // T4: illegal mnemonic dropped between legal ones; start ignored in RUN
    task automatic test_illegal();
        do_start(0);
        set_cmd(6'd0, 5'd1, 5'd2, 5'd3, 5'd7, 26'd0, 1'b0);
        start = 1'b1; base_addr = 10'd7;
        step();
        start = 1'b0;
        $display("t4 write addr=%0d data=%h", bus.im_addr, bus.im_wdata);
        checks++;
        if (bus.im_we !== 1'b1 || bus.im_addr !== 10'd0 || bus.im_wdata !== 32'h00221820) begin
            errors++;
            $display("FAIL t4_first: we=%b addr=%0d data=%h, required 1 0 00221820", bus.im_we, bus.im_addr, bus.im_wdata);
        end
        set_cmd(6'd40, 5'd1, 5'd1, 5'd1, 5'd0, 26'd0, 1'b0);
        step();
        $display("t4 illegal err=%b cnt=%0d", err_illegal, illegal_cnt);
        checks++;
        if (bus.im_we !== 1'b0 || err_illegal !== 1'b1 || illegal_cnt !== 8'd1) begin
            errors++;
            $display("FAIL t4_drop: we=%b err=%b cnt=%0d, required 0 1 1", bus.im_we, err_illegal, illegal_cnt);
        end
        set_cmd(6'd5, 5'd4, 5'd5, 5'd6, 5'd0, 26'd0, 1'b1);
        step();
        $display("t4 write addr=%0d data=%h", bus.im_addr, bus.im_wdata);
        checks++;
        if (bus.im_we !== 1'b1 || bus.im_addr !== 10'd1 || bus.im_wdata !== 32'h00853025 ||
            err_illegal !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL t4_second: we=%b addr=%0d data=%h err=%b done=%b, required 1 1 00853025 0 1",
                     bus.im_we, bus.im_addr, bus.im_wdata, err_illegal, done);
        end
        clear_cmd();
        step();
        // illegal command carrying last still finishes the load
        do_start(0);
        set_cmd(6'd63, 5'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b1);
        step();
        clear_cmd();
        $display("t4 illegal-last err=%b done=%b cnt=%0d", err_illegal, done, illegal_cnt);
        checks++;
        if (bus.im_we !== 1'b0 || err_illegal !== 1'b1 || done !== 1'b1 || illegal_cnt !== 8'd2) begin
            errors++;
            $display("FAIL t4_illegal_last: we=%b err=%b done=%b cnt=%0d, required 0 1 1 2",
                     bus.im_we, err_illegal, done, illegal_cnt);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL t4_idle: busy=%b, required 0", busy);
        end
    endtask

    // illegal counter saturates at 255; 35 is the first illegal index
    task automatic test_saturation();
        do_start(0);
        for (int i = 0; i < 260; i++) begin
            set_cmd(6'(35 + (i % 29)), 5'd0, 5'd0, 5'd0, 5'd0, 26'd0, (i == 259));
            step();
        end
        clear_cmd();
        $display("sat illegal_cnt=%0d", illegal_cnt);
        checks++;
        if (illegal_cnt !== 8'd255 || bus.im_we !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL sat_count: cnt=%0d we=%b done=%b, required 255 0 1", illegal_cnt, bus.im_we, done);
        end
        step();
    endtask

    // T5: ADDR_W=2, fill to the top, stall, restart from FULL; last at top gives done
    task automatic test_full();
        start2 = 1'b1; base_addr2 = 2'd2;
        step();
        start2 = 1'b0;
        set_cmd2(6'd0, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0);
        step();
        $display("t5 write addr=%0d data=%h", bus2.im_addr, bus2.im_wdata);
        checks++;
        if (bus2.im_we !== 1'b1 || bus2.im_addr !== 2'd2 || bus2.im_wdata !== 32'h00221820 || full2 !== 1'b0) begin
            errors++;
            $display("FAIL t5_w2: we=%b addr=%0d data=%h full=%b, required 1 2 00221820 0",
                     bus2.im_we, bus2.im_addr, bus2.im_wdata, full2);
        end
        set_cmd2(6'd2, 5'd4, 5'd5, 5'd6, 26'd0, 1'b0);
        step();
        $display("t5 write addr=%0d data=%h full=%b", bus2.im_addr, bus2.im_wdata, full2);
        checks++;
        if (bus2.im_we !== 1'b1 || bus2.im_addr !== 2'd3 || bus2.im_wdata !== 32'h00853022 ||
            full2 !== 1'b1 || bus2.cmd_ready !== 1'b0 || done2 !== 1'b0) begin
            errors++;
            $display("FAIL t5_w3: we=%b addr=%0d data=%h full=%b ready=%b done=%b, required 1 3 00853022 1 0 0",
                     bus2.im_we, bus2.im_addr, bus2.im_wdata, full2, bus2.cmd_ready, done2);
        end
        set_cmd2(6'd21, 5'd1, 5'd2, 5'd0, 26'h0BEEF, 1'b1);
        step();
        checks++;
        if (bus2.im_we !== 1'b0 || full2 !== 1'b1 || busy2 !== 1'b1 || bus2.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL t5_stall: we=%b full=%b busy=%b ready=%b, required 0 1 1 0",
                     bus2.im_we, full2, busy2, bus2.cmd_ready);
        end
        start2 = 1'b1; base_addr2 = 2'd0;
        step();
        start2 = 1'b0;
        checks++;
        if (full2 !== 1'b0 || bus2.cmd_ready !== 1'b1 || bus2.im_we !== 1'b0) begin
            errors++;
            $display("FAIL t5_restart: full=%b ready=%b we=%b, required 0 1 0", full2, bus2.cmd_ready, bus2.im_we);
        end
        step();
        clear_cmd();
        $display("t5 write addr=%0d data=%h done=%b", bus2.im_addr, bus2.im_wdata, done2);
        checks++;
        if (bus2.im_we !== 1'b1 || bus2.im_addr !== 2'd0 || bus2.im_wdata !== 32'h3422BEEF || done2 !== 1'b1) begin
            errors++;
            $display("FAIL t5_resume: we=%b addr=%0d data=%h done=%b, required 1 0 3422BEEF 1",
                     bus2.im_we, bus2.im_addr, bus2.im_wdata, done2);
        end
        step();
        // final write lands at the top slot: done, not full
        start2 = 1'b1; base_addr2 = 2'd3;
        step();
        start2 = 1'b0;
        set_cmd2(6'd0, 5'd1, 5'd2, 5'd3, 26'd0, 1'b1);
        step();
        clear_cmd();
        $display("t5 top write addr=%0d done=%b full=%b", bus2.im_addr, done2, full2);
        checks++;
        if (bus2.im_we !== 1'b1 || bus2.im_addr !== 2'd3 || done2 !== 1'b1 || full2 !== 1'b0) begin
            errors++;
            $display("FAIL t5_top_last: we=%b addr=%0d done=%b full=%b, required 1 3 1 0",
                     bus2.im_we, bus2.im_addr, done2, full2);
        end
        step();
        checks++;
        if (busy2 !== 1'b0 || full2 !== 1'b0) begin
            errors++;
            $display("FAIL t5_top_idle: busy=%b full=%b, required 0 0", busy2, full2);
        end
    endtask

    // T6: reset right after an accept drops the pending write
    task automatic test_reset_mid_load();
        do_start(0);
        set_cmd(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0, 1'b0);
        step();
        rst = 1'b1;
        #1;
        checks++;
        if (bus.im_we !== 1'b0) begin
            errors++;
            $display("FAIL t6_pending: we=%b, required 0", bus.im_we);
        end
        step();
        $display("t6 reset busy=%b cnt=%0d", busy, illegal_cnt);
        checks++;
        if ({bus.im_we, bus.cmd_ready, busy, done, full, err_illegal} !== 6'b0 ||
            illegal_cnt !== 8'd0 || bus.im_addr !== '0 || bus.im_wdata !== 32'd0) begin
            errors++;
            $display("FAIL t6_outputs: we/ready/busy/done/full/err=%b cnt=%0d addr=%0d data=%h, required all zero",
                     {bus.im_we, bus.cmd_ready, busy, done, full, err_illegal}, illegal_cnt, bus.im_addr, bus.im_wdata);
        end
        rst = 1'b0;
        step();
        checks++;
        if (bus.im_we !== 1'b0 || bus.cmd_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL t6_stall: we=%b ready=%b busy=%b, required 0 0 0", bus.im_we, bus.cmd_ready, busy);
        end
        clear_cmd();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_formats();
        test_illegal();
        test_saturation();
        test_full();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
